// File: rtl/accel_shot_capture.sv
// Accelerometer "shot" detector: per-sample flick magnitude, shot tracking FSM with
// peak/length capture, post-shot holdoff and a freezable peak display.
module accel_shot_capture #(
  parameter int unsigned NUM_AXES        = 3,
  parameter int unsigned DATA_W          = 16,
  parameter int unsigned TRIG_TH         = 400,
  parameter int unsigned REL_TH          = 200,
  parameter int unsigned END_SAMPLES     = 4,
  parameter int unsigned MAX_SAMPLES     = 255,
  parameter int unsigned HOLDOFF_SAMPLES = 16,
  localparam int unsigned MAG_W          = DATA_W + 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       s_valid,
  input  logic [NUM_AXES*DATA_W-1:0] s_data,
  input  logic                       freeze,
  output logic [MAG_W-1:0]           mag,
  output logic                       mag_valid,
  output logic [MAG_W-1:0]           disp,
  output logic                       busy,
  output logic                       shot_valid,
  output logic [MAG_W-1:0]           shot_peak,
  output logic [7:0]                 shot_len
);

  localparam int unsigned QW = (END_SAMPLES < 2) ? 1 : $clog2(END_SAMPLES + 1);
  localparam int unsigned HW = (HOLDOFF_SAMPLES < 2) ? 1 : $clog2(HOLDOFF_SAMPLES + 1);

  typedef enum logic [1:0] {StIdle, StTrack, StDone, StHoldoff} state_e;

  // ---------------------------------------------------------------- magnitude stage
  logic [NUM_AXES*DATA_W-1:0] x_prev_q;
  logic                       prev_valid_q;
  logic [MAG_W-1:0]           mag_q, mag_d;
  logic                       mag_valid_q;

  logic signed [DATA_W+1:0] cur_ext, prv_ext, diff;
  logic        [DATA_W:0]   delta;

  // Two guard bits keep x - x_prev exact at the extremes; the abs fits in DATA_W+1 bits.
  always_comb begin
    mag_d   = '0;
    cur_ext = '0;
    prv_ext = '0;
    diff    = '0;
    delta   = '0;
    for (int i = 0; i < NUM_AXES; i++) begin
      cur_ext = {{2{s_data[i*DATA_W+DATA_W-1]}}, s_data[i*DATA_W +: DATA_W]};
      prv_ext = {{2{x_prev_q[i*DATA_W+DATA_W-1]}}, x_prev_q[i*DATA_W +: DATA_W]};
      diff    = cur_ext - prv_ext;
      delta   = (diff[DATA_W:0] ^ {(DATA_W+1){diff[DATA_W+1]}})
              + {{DATA_W{1'b0}}, diff[DATA_W+1]};
      if (prev_valid_q) mag_d = mag_d + {2'b00, delta};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_prev_q     <= '0;
      prev_valid_q <= 1'b0;
      mag_q        <= '0;
      mag_valid_q  <= 1'b0;
    end else begin
      mag_valid_q <= s_valid;
      if (s_valid) begin
        mag_q        <= mag_d;
        x_prev_q     <= s_data;
        prev_valid_q <= 1'b1;
      end
    end
  end

  assign mag       = mag_q;
  assign mag_valid = mag_valid_q;

  // ---------------------------------------------------------------- shot FSM
  state_e           state_q, state_d;
  logic [MAG_W-1:0] peak_q, peak_d;
  logic [7:0]       len_q, len_d;
  logic [QW-1:0]    quiet_q, quiet_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [MAG_W-1:0] shot_peak_q, shot_peak_d;
  logic [7:0]       shot_len_q, shot_len_d;

  always_comb begin
    state_d     = state_q;
    peak_d      = peak_q;
    len_d       = len_q;
    quiet_d     = quiet_q;
    hold_d      = hold_q;
    shot_peak_d = shot_peak_q;
    shot_len_d  = shot_len_q;
    unique case (state_q)
      StIdle: begin
        if (mag_valid_q && (mag_q >= MAG_W'(TRIG_TH))) begin
          state_d = StTrack;
          peak_d  = mag_q;
          len_d   = 8'd1;
          quiet_d = '0;
        end
      end
      StTrack: begin
        if (mag_valid_q) begin
          len_d   = len_q + 8'd1;
          peak_d  = (mag_q > peak_q) ? mag_q : peak_q;
          quiet_d = (mag_q < MAG_W'(REL_TH)) ? quiet_q + 1'b1 : '0;
          // Results load on entry so they are already valid during the DONE strobe.
          if ((quiet_d == QW'(END_SAMPLES)) || (len_d == 8'(MAX_SAMPLES))) begin
            state_d     = StDone;
            shot_peak_d = peak_d;
            shot_len_d  = len_d;
          end
        end
      end
      StDone: begin
        hold_d  = '0;
        state_d = (HOLDOFF_SAMPLES == 0) ? StIdle : StHoldoff;
      end
      StHoldoff: begin
        if (mag_valid_q) begin
          hold_d = hold_q + 1'b1;
          if (hold_d == HW'(HOLDOFF_SAMPLES)) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      peak_q      <= '0;
      len_q       <= '0;
      quiet_q     <= '0;
      hold_q      <= '0;
      shot_peak_q <= '0;
      shot_len_q  <= '0;
    end else begin
      state_q     <= state_d;
      peak_q      <= peak_d;
      len_q       <= len_d;
      quiet_q     <= quiet_d;
      hold_q      <= hold_d;
      shot_peak_q <= shot_peak_d;
      shot_len_q  <= shot_len_d;
    end
  end

  assign busy       = (state_q == StTrack);
  assign shot_valid = (state_q == StDone);
  assign shot_peak  = shot_peak_q;
  assign shot_len   = shot_len_q;

  // ---------------------------------------------------------------- display freeze
  logic             freeze_q;
  logic [MAG_W-1:0] frz_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      freeze_q <= 1'b0;
      frz_q    <= '0;
    end else begin
      freeze_q <= freeze;
      if (freeze && !freeze_q) frz_q <= shot_peak_q;
    end
  end

  // On the rising-edge cycle frz_q is still loading, so show the value being captured.
  assign disp = (freeze && freeze_q) ? frz_q : shot_peak_q;

endmodule

// File: tb/tb_accel_shot_capture.sv
// Self-checking bench for accel_shot_capture: table-driven magnitude vectors with a
// scoreboard of expected mags, plus hand sequences for shots, holdoff, freeze and reset.
module tb_accel_shot_capture;

  localparam int unsigned NAX   = 4;
  localparam int unsigned DW    = 16;
  localparam int unsigned MAG_W = DW + 3;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                s_valid;
  logic [NAX*DW-1:0]   s_data;
  logic                freeze;
  logic [MAG_W-1:0]    mag;
  logic                mag_valid;
  logic [MAG_W-1:0]    disp;
  logic                busy;
  logic                shot_valid;
  logic [MAG_W-1:0]    shot_peak;
  logic [7:0]          shot_len;

  // Four axes so the full-scale case can be exercised; 3-axis cases keep axis 3 fixed.
  accel_shot_capture #(.NUM_AXES(NAX)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .freeze     (freeze),
    .mag        (mag),
    .mag_valid  (mag_valid),
    .disp       (disp),
    .busy       (busy),
    .shot_valid (shot_valid),
    .shot_peak  (shot_peak),
    .shot_len   (shot_len)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    int unsigned exp_mag;
  } vec_t;

  int          tests = 0;
  int          fails = 0;
  int unsigned exp_q[$];
  int          shot_cnt = 0;
  logic [MAG_W-1:0] last_peak = '0;
  logic [7:0]       last_len = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pk(input int a, input int b, input int c, input int d);
    return {d[15:0], c[15:0], b[15:0], a[15:0]};
  endfunction

  // Scoreboard: every mag strobe is matched against the oldest expected value.
  always @(posedge clk) begin
    #1;
    if (mag_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("mag_unexpected_strobe", 64'd1, 64'd0);
      end else begin
        check("mag", {45'd0, mag}, {32'd0, exp_q.pop_front()});
      end
    end
    if (shot_valid === 1'b1) begin
      shot_cnt++;
      last_peak = shot_peak;
      last_len  = shot_len;
    end
  end

  task automatic send(input logic [63:0] data, input int unsigned exp, input bit b2b);
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = data;
    exp_q.push_back(exp);
    if (!b2b) begin
      @(negedge clk);
      s_valid = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      s_valid = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n   = 1'b0;
    s_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
  endtask

  task automatic wait_shot(input int max_cycles);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(posedge clk);
      #1;
      if (shot_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check("shot_valid_seen", {63'd0, seen}, 64'd1);
  endtask

  vec_t tbl[14];

  initial begin
    for (int i = 0; i < 10; i++) tbl[i] = '{pk(1000, 1000, 1000, 0), 0};
    tbl[10] = '{pk(1100, 900, 1000, 0), 200};
    tbl[11] = '{pk(1000, 1000, 1000, -50), 250};
    tbl[12] = '{pk(1000, 1000, 1150, 100), 300};
    tbl[13] = '{pk(1000, 1000, 1150, -100), 200};

    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; freeze = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    check("rst_mag", {45'd0, mag}, 64'd0);
    check("rst_mag_valid", {63'd0, mag_valid}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_shot_valid", {63'd0, shot_valid}, 64'd0);
    check("rst_shot_peak", {45'd0, shot_peak}, 64'd0);
    check("rst_shot_len", {56'd0, shot_len}, 64'd0);
    check("rst_disp", {45'd0, disp}, 64'd0);

    // Constant input then small mixed deltas, back-to-back: never a shot
    for (int i = 0; i < 14; i++) send(tbl[i].data, tbl[i].exp_mag, 1'b1);
    idle(4);
    check("quiet_busy", {63'd0, busy}, 64'd0);
    check("quiet_no_shot", 64'(shot_cnt), 64'd0);

    // Single 500 step: trigger, four quiet samples, shot of length 5
    do_reset();
    send(pk(0, 0, 0, 0), 0, 1'b0);
    send(pk(500, 0, 0, 0), 500, 1'b0);
    idle(2);
    check("step_busy", {63'd0, busy}, 64'd1);
    for (int i = 0; i < 4; i++) send(pk(500, 0, 0, 0), 0, 1'b0);
    wait_shot(20);
    check("step_shot_cnt", 64'(shot_cnt), 64'd1);
    check("step_peak", {45'd0, last_peak}, 64'd500);
    check("step_len", {56'd0, last_len}, 64'd5);
    check("step_busy_done", {63'd0, busy}, 64'd0);
    check("step_disp", {45'd0, disp}, 64'd500);

    // Trigger-level sample at holdoff strobe 5 is ignored; after 16 strobes it retriggers
    for (int i = 0; i < 4; i++) send(pk(500, 0, 0, 0), 0, 1'b0);
    send(pk(0, 0, 0, 0), 500, 1'b0);
    idle(2);
    check("holdoff_busy", {63'd0, busy}, 64'd0);
    for (int i = 0; i < 11; i++) send(pk(0, 0, 0, 0), 0, 1'b0);
    check("holdoff_no_shot", 64'(shot_cnt), 64'd1);
    send(pk(500, 0, 0, 0), 500, 1'b0);
    idle(2);
    check("after_holdoff_busy", {63'd0, busy}, 64'd1);
    for (int i = 0; i < 4; i++) send(pk(500, 0, 0, 0), 0, 1'b0);
    wait_shot(20);
    check("retrig_shot_cnt", 64'(shot_cnt), 64'd2);
    check("retrig_len", {56'd0, last_len}, 64'd5);

    // Freeze holds 500 while a 900 shot completes underneath
    freeze = 1'b1;
    idle(2);
    check("frz_disp_500", {45'd0, disp}, 64'd500);
    for (int i = 0; i < 16; i++) send(pk(500, 0, 0, 0), 0, 1'b0);
    send(pk(1400, 0, 0, 0), 900, 1'b0);
    for (int i = 0; i < 4; i++) send(pk(1400, 0, 0, 0), 0, 1'b0);
    wait_shot(20);
    check("frz_shot_cnt", 64'(shot_cnt), 64'd3);
    check("frz_new_peak", {45'd0, last_peak}, 64'd900);
    idle(2);
    check("frz_disp_held", {45'd0, disp}, 64'd500);
    freeze = 1'b0;
    #1;
    check("unfrz_disp", {45'd0, disp}, 64'd900);

    // Full-scale alternation on 4 axes, back-to-back, runs to the length limit
    for (int i = 0; i < 16; i++) send(pk(1400, 0, 0, 0), 0, 1'b0);
    for (int i = 0; i < 255; i++) begin
      int v;
      v = (i % 2 == 0) ? -32768 : 32767;
      send(pk(v, v, v, v), (i == 0) ? 132472 : 262140, 1'b1);
    end
    @(negedge clk);
    s_valid = 1'b0;
    wait_shot(20);
    freeze = 1'b1;  // rising edge lands in the DONE cycle
    check("max_shot_cnt", 64'(shot_cnt), 64'd4);
    check("max_len", {56'd0, last_len}, 64'd255);
    check("max_peak", {45'd0, last_peak}, 64'd262140);
    idle(3);
    check("frz_at_done_disp", {45'd0, disp}, 64'd262140);
    freeze = 1'b0;

    // Reset mid-TRACK abandons the shot
    for (int i = 0; i < 16; i++) send(pk(-32768, -32768, -32768, -32768), 0, 1'b0);
    send(pk(-32268, -32768, -32768, -32768), 500, 1'b0);
    idle(2);
    check("pre_rst_busy", {63'd0, busy}, 64'd1);
    do_reset();
    check("post_rst_busy", {63'd0, busy}, 64'd0);
    check("post_rst_shot_peak", {45'd0, shot_peak}, 64'd0);
    check("post_rst_shot_len", {56'd0, shot_len}, 64'd0);
    check("post_rst_mag", {45'd0, mag}, 64'd0);
    idle(4);
    check("post_rst_no_shot", 64'(shot_cnt), 64'd4);
    send(pk(1000, 1000, 1000, 1000), 0, 1'b0);
    idle(3);
    check("post_rst_busy2", {63'd0, busy}, 64'd0);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1, expected 0");
    $fatal(1, "timeout");
  end

endmodule
